// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Holds the controller state encoding and the slice-index width rule.
package seq_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  // Width of the slice index; at least one bit so NCH=1 still has a register.
  function automatic int idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_add.sv
// CHUNK-bit combinational ripple adder with carry in/out.
// One instance is time-shared across every slice of the wide operands.
module chunk_add #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] total;

  assign total   = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  assign {co, s} = total;

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit a+b+cin computed CHUNK bits per clock
// through a registered carry, with start/busy/done handshake.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = idx_width(NCH);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  state_t                     state;
  logic [WIDTH-1:0]           a_q;
  logic [WIDTH-1:0]           b_q;
  logic [NCH-1:0][CHUNK-1:0]  psum_q;
  logic                       carry_q;
  logic [IW-1:0]              idx_q;

  // Slice views of the captured operands, selected by the running index.
  logic [NCH-1:0][CHUNK-1:0]  a_sl;
  logic [NCH-1:0][CHUNK-1:0]  b_sl;
  logic [CHUNK-1:0]           x_sl;
  logic [CHUNK-1:0]           y_sl;
  logic [CHUNK-1:0]           s_sl;
  logic                       co_sl;
  logic [NCH-1:0][CHUNK-1:0]  psum_nxt;

  assign a_sl = a_q;
  assign b_sl = b_q;

  // NOTE: every always_comb output gets a full default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    x_sl            = a_sl[idx_q];
    y_sl            = b_sl[idx_q];
    psum_nxt        = psum_q;
    psum_nxt[idx_q] = s_sl;
  end

  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .x  (x_sl),
    .y  (y_sl),
    .ci (carry_q),
    .s  (s_sl),
    .co (co_sl)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      psum_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            psum_q  <= '0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          psum_q  <= psum_nxt;
          carry_q <= co_sl;
          if (idx_q == LAST) begin
            sum      <= psum_nxt;
            cout     <= co_sl;
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (psum_nxt[NCH-1][CHUNK-1] != a_q[WIDTH-1]);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench: directed 8-bit vectors plus exhaustive 4-bit sweeps
// for CHUNK = 2, 4 and 1.
module tb_seq_chunk_adder;

  typedef struct packed {
    logic       cout;
    logic       ovf;
    logic [7:0] sum;
  } exp8_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- 8-bit / 2-bit-chunk instance ----------------
  logic       reset8, start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  exp8_t      q8[$];

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk      (clk),
    .reset    (reset8),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ovf8)
  );

  always @(negedge clk) begin : mon8
    exp8_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        fail_now("done8_unexpected: got done=1, expected no pending result");
      end else begin
        e = q8.pop_front();
        check("sum8",  32'(sum8),  32'(e.sum));
        check("cout8", 32'(cout8), 32'(e.cout));
        check("ovf8",  32'(ovf8),  32'(e.ovf));
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] esum, input logic ecout, input logic eovf);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back('{cout: ecout, ovf: eovf, sum: esum});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input string name);
    for (int t = 0; t < 16 && !done8; t++) @(negedge clk);
    if (!done8) fail_now({name, "_timeout: no done within 16 cycles"});
  endtask

  // ---------------- 4-bit exhaustive instances ----------------
  logic       reset4;
  logic       ex_go = 1'b0;
  logic [2:0] ex_fin = 3'b000;

  for (genvar g = 0; g < 3; g++) begin : g4
    localparam int CH = (g == 0) ? 2 : (g == 1) ? 4 : 1;
    logic       start, cin, busy, done, cout, ovf;
    logic [3:0] a, b, sum;
    logic [5:0] q[$];

    seq_chunk_adder #(.WIDTH(4), .CHUNK(CH)) u_dut4 (
      .clk      (clk),
      .reset    (reset4),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (ovf)
    );

    always @(negedge clk) begin : mon4
      logic [5:0] e;
      if (done) begin
        if (q.size() == 0) begin
          fail_now($sformatf("done4_c%0d_unexpected", CH));
        end else begin
          e = q.pop_front();
          check($sformatf("exh_c%0d {cout,ovf,sum}", CH), 32'({cout, ovf, sum}), 32'(e));
        end
      end
    end

    initial begin : stim4
      logic [4:0] full;
      logic       eovf;
      start = 1'b0; a = '0; b = '0; cin = 1'b0;
      wait (ex_go);
      for (int x = 0; x < 512; x++) begin
        @(negedge clk);
        a   = 4'(x);
        b   = 4'(x >> 4);
        cin = 1'(x >> 8);
        full = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        eovf = (a[3] == b[3]) && (full[3] != a[3]);
        q.push_back({full[4], eovf, full[3:0]});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 16 && !done; t++) @(negedge clk);
        if (!done) fail_now($sformatf("exh_c%0d_timeout case %0d", CH, x));
      end
      @(negedge clk);
      check($sformatf("exh_c%0d_queue_empty", CH), 32'(q.size()), 32'd0);
      ex_fin[g] = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int seen;
    reset8 = 1'b1; reset4 = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (3) @(negedge clk);
    reset8 = 1'b0; reset4 = 1'b0;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum",  32'(sum8),  32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_ovf",  32'(ovf8),  32'd0);

    // 0x5A + 0x3C: four busy cycles, done on the fourth ADD edge.
    issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_busy_c%0d", i), 32'(busy8), 32'd1);
      check($sformatf("t1_nodone_c%0d", i), 32'(done8), 32'd0);
      @(negedge clk);
    end
    check("t1_done", 32'(done8), 32'd1);
    check("t1_busy_low", 32'(busy8), 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done8), 32'd0);
    check("t1_sum_held", 32'(sum8), 32'h96);

    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_done8("t2");
    issue8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    wait_done8("t3");

    // Start during busy is ignored; operand changes after capture too.
    issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    wait_done8("t4");

    // Back-to-back: start asserted in the done cycle.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{cout: 1'b0, ovf: 1'b0, sum: 8'h02});
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_accept", 32'(busy8), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_busy_c%0d", i), 32'(busy8), 32'd1);
      check($sformatf("b2b_nodone_c%0d", i), 32'(done8), 32'd0);
    end
    @(negedge clk);
    check("b2b_done", 32'(done8), 32'd1);

    // Reset in the second ADD cycle aborts the operation.
    issue8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    reset8 = 1'b1;
    q8.delete();
    @(negedge clk);
    reset8 = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum",  32'(sum8),  32'd0);
    check("abort_cout", 32'(cout8), 32'd0);
    check("abort_ovf",  32'(ovf8),  32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_done8("t5");
    @(negedge clk);
    check("q8_empty", 32'(q8.size()), 32'd0);

    ex_go = 1'b1;
    for (int t = 0; t < 20000 && ex_fin != 3'b111; t++) @(negedge clk);
    if (ex_fin != 3'b111) fail_now("exhaustive_timeout: sweeps did not finish");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
